// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB3 memory slave: a DEPTH-word register file with separately programmable
// read and write wait states, byte-lane write strobes, and PSLVERR on
// misaligned or out-of-range accesses. Memory is cleared by reset.
//
// Parameters
//   ADDR_WIDTH  PADDR width (byte address)
//   DATA_WIDTH  PWDATA/PRDATA width: 8, 16, 32 or 64
//   DEPTH       number of words (any value, power of two not required)
//   RD_WAIT     wait cycles on reads  (0..15)
//   WR_WAIT     wait cycles on writes (0..15)
//
// Ports
//   i_clk      in   clock, rising edge
//   i_reset_n  in   asynchronous active-low reset
//   PADDR      in   byte address
//   PWRITE     in   1 = write, 0 = read
//   PWDATA     in   write data
//   PSTRB      in   byte-lane write enables (ignored on reads)
//   PSELx      in   slave select
//   PENABLE    in   access phase
//   PRDATA     out  read data, registered at the setup edge
//   PREADY     out  transfer complete (combinational)
//   PSLVERR    out  error, qualified by PREADY
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no transfer; waiting for a setup phase (PSELx=1, PENABLE=0)
// ACCESS | transfer latched; counting wait states, completes when the
//        | counter is zero with PSELx and PENABLE both high
// -----------------------------------------------------------------------------
module apb_slave_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int RD_WAIT    = 0,
   parameter int WR_WAIT    = 0
) (
   input  logic                    i_clk,
   input  logic                    i_reset_n,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic                    PWRITE,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   input  logic                    PSELx,
   input  logic                    PENABLE,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int NUM_LANES = DATA_WIDTH / 8;
   localparam int LSB       = $clog2(NUM_LANES);
   localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Low address bits that must be zero for a word-aligned access. For an
   // 8-bit data path this mask is empty and nothing can be misaligned.
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);

   localparam logic [3:0] RD_WAIT_C = 4'(RD_WAIT);
   localparam logic [3:0] WR_WAIT_C = 4'(WR_WAIT);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t state;
   state_t state_next;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] word_addr;
   logic [IDX_W-1:0]      word_idx;
   logic                  addr_err;
   logic                  setup;

   logic                  dir_write_q;
   logic                  err_q;
   logic [IDX_W-1:0]      idx_q;
   logic [3:0]            wait_cnt;
   logic                  cnt_zero;

   logic                  latch_en;
   logic                  dec_en;
   logic                  commit_en;

   // ---------------------------------------------------------------------------
   // Address decode (evaluated on the setup-phase address, then registered)
   // ---------------------------------------------------------------------------
   assign word_addr = PADDR >> LSB;
   assign word_idx  = word_addr[IDX_W-1:0];

   // The range test is done on the full word address so that high address
   // bits cannot alias back into the array through the truncated index.
   assign addr_err  = ((PADDR & ALIGN_MASK) != '0) ||
                      (64'(word_addr) >= 64'(DEPTH));

   assign setup     = PSELx && !PENABLE;
   assign cnt_zero  = (wait_cnt == 4'd0);

   // ---------------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      latch_en   = 1'b0;
      dec_en     = 1'b0;
      commit_en  = 1'b0;
      PREADY     = 1'b0;
      case (state)
         IDLE: begin
            // PENABLE without a preceding setup is ignored here.
            if (setup) begin
               latch_en   = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (!PSELx) begin
               // Master abandoned the transfer: drop it without a write.
               state_next = IDLE;
            end else if (PENABLE) begin
               if (cnt_zero) begin
                  PREADY     = 1'b1;
                  commit_en  = dir_write_q && !err_q;
                  // A setup overlapping completion is not legal APB; it is
                  // not accepted, so the FSM always returns to IDLE here.
                  state_next = IDLE;
               end else begin
                  dec_en = 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign PSLVERR = PREADY && err_q;

   // ---------------------------------------------------------------------------
   // Transfer context, wait counter and read data register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         dir_write_q <= 1'b0;
         err_q       <= 1'b0;
         idx_q       <= '0;
         wait_cnt    <= 4'd0;
         PRDATA      <= '0;
      end else begin
         if (latch_en) begin
            dir_write_q <= PWRITE;
            err_q       <= addr_err;
            idx_q       <= word_idx;
            wait_cnt    <= PWRITE ? WR_WAIT_C : RD_WAIT_C;
            // PRDATA is only refreshed by a read setup; writes leave the last
            // read value in place.
            if (!PWRITE) begin
               if (addr_err) begin
                  PRDATA <= '0;
               end else begin
                  PRDATA <= mem[word_idx];
               end
            end
         end else if (dec_en) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Storage: byte-lane writes on the completion edge only
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (commit_en) begin
         for (int b = 0; b < NUM_LANES; b++) begin
            if (PSTRB[b]) begin
               mem[idx_q][8*b +: 8] <= PWDATA[8*b +: 8];
            end
         end
      end
   end

endmodule
